// File: rtl/vga_pkg.sv
// Shared definitions for the VGA console writer: text geometry, buffer map,
// ASCII control codes and the writer FSM state encoding.
package vga_pkg;

    localparam int          N_COL    = 80;
    localparam int          N_ROW    = 30;
    localparam logic [14:0] BUF_BASE = 15'h4000;
    localparam logic [14:0] REG_BASE = 15'h2000;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WRITE        = 3'd1,
        ST_WAIT_B       = 3'd2,
        ST_CLEAR_WRITE  = 3'd3,
        ST_CLEAR_WAIT_B = 3'd4
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_axil_wr_master.sv
// Single-outstanding AXI-lite write engine: start loads address/data/strobe,
// AW and W complete independently, then one B beat is taken.
module vga_axil_wr_master #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   strb_i,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic [ADDR_W-1:0]     m_awaddr_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,
    input  logic [1:0]            m_bresp_i,
    output logic                  data_done_o,
    output logic                  done_o,
    output logic                  err_o
);

    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  bready_q,  bready_d;
    logic [ADDR_W-1:0]     awaddr_q,  awaddr_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q,   wstrb_d;

    // Channel valids and payload registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Handshake sequencing; start wins because the caller only issues it when the engine is free
    always_comb begin
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        data_done_o = 1'b0;
        if (start_i) begin
            awaddr_d  = addr_i;
            wdata_d   = data_i;
            wstrb_d   = strb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b0;
        end else if (awvalid_q || wvalid_q) begin
            if (m_awready_i) awvalid_d = 1'b0;
            else             awvalid_d = awvalid_q;
            if (m_wready_i)  wvalid_d  = 1'b0;
            else             wvalid_d  = wvalid_q;
            if (!awvalid_d && !wvalid_d) begin
                bready_d    = 1'b1;
                data_done_o = 1'b1;
            end else begin
                bready_d    = 1'b0;
            end
        end else if (bready_q && m_bvalid_i) begin
            bready_d = 1'b0;
        end else begin
            bready_d = bready_q;
        end
    end

    assign done_o      = bready_q & m_bvalid_i;
    assign err_o       = done_o & (m_bresp_i != 2'b00);
    assign m_awvalid_o = awvalid_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_bready_o  = bready_q;
    assign m_awaddr_o  = awaddr_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;

endmodule

// File: rtl/vga_console_writer.sv
// Turns an ASCII byte stream into AXI-lite writes into the VGA character
// buffer, tracking a text cursor and handling CR, LF, BS and FF.
module vga_console_writer
    import vga_pkg::*;
#(
    parameter int                          C_AXI_DATA_WIDTH = 32,
    parameter int                          C_AXI_ADDR_WIDTH = 15,
    parameter int                          N_COL            = 80,
    parameter int                          N_ROW            = 30,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BUF_BASE         = 15'h4000
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            char_valid_i,
    input  logic [7:0]                      char_data_i,
    output logic                            char_ready_o,
    output logic                            m_awvalid_o,
    input  logic                            m_awready_i,
    output logic [C_AXI_ADDR_WIDTH-1:0]     m_awaddr_o,
    output logic                            m_wvalid_o,
    input  logic                            m_wready_i,
    output logic [C_AXI_DATA_WIDTH-1:0]     m_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   m_wstrb_o,
    input  logic                            m_bvalid_i,
    output logic                            m_bready_o,
    input  logic [1:0]                      m_bresp_i,
    output logic [6:0]                      cursor_col_o,
    output logic [4:0]                      cursor_row_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int                STRB_W   = C_AXI_DATA_WIDTH / 8;
    localparam int                N_WORDS  = (N_COL * N_ROW) / 4;
    localparam logic [6:0]        LAST_COL = 7'(N_COL - 1);
    localparam logic [4:0]        LAST_ROW = 5'(N_ROW - 1);
    localparam logic [9:0]        LAST_IDX = 10'(N_WORDS - 1);
    localparam logic [STRB_W-1:0] STRB_LSB = STRB_W'(1);

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [9:0]  idx_q, idx_d;
    logic        is_bs_q, is_bs_d;
    logic        err_q, err_d;
    logic        char_ready_q, char_ready_d;
    logic        busy_q, busy_d;

    logic                        start_s;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_s;
    logic [C_AXI_DATA_WIDTH-1:0] data_s;
    logic [STRB_W-1:0]           strb_s;
    logic [11:0]                 tile_cur_s, tile_bs_s;
    logic [9:0]                  idx_inc_s;
    logic                        accept_s;
    logic                        eng_data_done_s, eng_done_s, eng_err_s;

    assign tile_cur_s = 12'(row_q) * 12'(N_COL) + 12'(col_q);
    assign tile_bs_s  = 12'(row_q) * 12'(N_COL) + 12'(col_q - 7'd1);
    assign idx_inc_s  = idx_q + 10'd1;
    assign accept_s   = char_valid_i && char_ready_q;

    // FSM, cursor, clear index and status registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            col_q        <= 7'd0;
            row_q        <= 5'd0;
            idx_q        <= 10'd0;
            is_bs_q      <= 1'b0;
            err_q        <= 1'b0;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            is_bs_q      <= is_bs_d;
            err_q        <= err_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Character decode, write launch and cursor bookkeeping
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        is_bs_d = is_bs_q;
        err_d   = err_q;
        start_s = 1'b0;
        addr_s  = '0;
        data_s  = '0;
        strb_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (is_printable(char_data_i)) begin
                    start_s = 1'b1;
                    addr_s  = BUF_BASE | C_AXI_ADDR_WIDTH'(tile_cur_s);
                    data_s  = {STRB_W{char_data_i}};
                    strb_s  = STRB_LSB << tile_cur_s[1:0];
                    is_bs_d = 1'b0;
                    state_d = ST_WRITE;
                end else begin
                    case (char_data_i)
                        CR: col_d = 7'd0;
                        LF: begin
                            col_d = 7'd0;
                            row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
                        end
                        BS: begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                start_s = 1'b1;
                                addr_s  = BUF_BASE | C_AXI_ADDR_WIDTH'(tile_bs_s);
                                data_s  = {STRB_W{SPACE}};
                                strb_s  = STRB_LSB << tile_bs_s[1:0];
                                is_bs_d = 1'b1;
                                state_d = ST_WRITE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        FF: begin
                            idx_d   = 10'd0;
                            col_d   = 7'd0;
                            row_d   = 5'd0;
                            start_s = 1'b1;
                            addr_s  = BUF_BASE;
                            data_s  = {STRB_W{SPACE}};
                            strb_s  = {STRB_W{1'b1}};
                            state_d = ST_CLEAR_WRITE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                if (eng_data_done_s) state_d = ST_WAIT_B;
                else                 state_d = ST_WRITE;
            end
            ST_WAIT_B: begin
                if (eng_done_s) begin
                    err_d   = err_q | eng_err_s;
                    state_d = ST_IDLE;
                    // Backspace already moved the cursor when it was decoded
                    if (is_bs_q) begin
                        col_d = col_q;
                    end else if (col_q == LAST_COL) begin
                        col_d = 7'd0;
                        row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_CLEAR_WRITE: begin
                if (eng_data_done_s) state_d = ST_CLEAR_WAIT_B;
                else                 state_d = ST_CLEAR_WRITE;
            end
            ST_CLEAR_WAIT_B: begin
                if (!eng_done_s) begin
                    state_d = ST_CLEAR_WAIT_B;
                end else if (idx_q == LAST_IDX) begin
                    err_d   = err_q | eng_err_s;
                    state_d = ST_IDLE;
                end else begin
                    err_d   = err_q | eng_err_s;
                    idx_d   = idx_inc_s;
                    start_s = 1'b1;
                    addr_s  = BUF_BASE + C_AXI_ADDR_WIDTH'({idx_inc_s, 2'b00});
                    data_s  = {STRB_W{SPACE}};
                    strb_s  = {STRB_W{1'b1}};
                    state_d = ST_CLEAR_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        char_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    vga_axil_wr_master #(
        .ADDR_W (C_AXI_ADDR_WIDTH),
        .DATA_W (C_AXI_DATA_WIDTH)
    ) u_wr_master (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_s),
        .addr_i      (addr_s),
        .data_i      (data_s),
        .strb_i      (strb_s),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_awaddr_o  (m_awaddr_o),
        .m_wvalid_o  (m_wvalid_o),
        .m_wready_i  (m_wready_i),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_bvalid_i  (m_bvalid_i),
        .m_bready_o  (m_bready_o),
        .m_bresp_i   (m_bresp_i),
        .data_done_o (eng_data_done_s),
        .done_o      (eng_done_s),
        .err_o       (eng_err_s)
    );

    assign char_ready_o = char_ready_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed self-checking bench for vga_console_writer with a small AXI-lite
// slave responder that records every completed write.
module tb_vga_console_writer;

    localparam int BOUND = 5000;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        char_valid_i;
    logic [7:0]  char_data_i;
    logic        char_ready_o;
    logic        m_awvalid_o, m_awready_i;
    logic [14:0] m_awaddr_o;
    logic        m_wvalid_o, m_wready_i;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_bvalid_i, m_bready_o;
    logic [1:0]  m_bresp_i;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;
    logic        busy_o, err_o;

    logic [1:0]  bresp_cfg;
    logic        got_aw, got_w;
    logic [14:0] cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_strb;
    logic [14:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_strb_q[$];

    int checks   = 0;
    int failures = 0;

    vga_console_writer dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .char_valid_i (char_valid_i),
        .char_data_i  (char_data_i),
        .char_ready_o (char_ready_o),
        .m_awvalid_o  (m_awvalid_o),
        .m_awready_i  (m_awready_i),
        .m_awaddr_o   (m_awaddr_o),
        .m_wvalid_o   (m_wvalid_o),
        .m_wready_i   (m_wready_i),
        .m_wdata_o    (m_wdata_o),
        .m_wstrb_o    (m_wstrb_o),
        .m_bvalid_i   (m_bvalid_i),
        .m_bready_o   (m_bready_o),
        .m_bresp_i    (m_bresp_i),
        .cursor_col_o (cursor_col_o),
        .cursor_row_o (cursor_row_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Slave: record a write once both AW and W are taken, answer B the next cycle
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            m_bvalid_i <= 1'b0;
            m_bresp_i  <= 2'b00;
        end else begin
            if (m_bvalid_i && m_bready_o) m_bvalid_i <= 1'b0;
            if ((got_aw || (m_awvalid_o && m_awready_i)) && (got_w || (m_wvalid_o && m_wready_i))) begin
                wr_addr_q.push_back(got_aw ? cap_addr : m_awaddr_o);
                wr_data_q.push_back(got_w ? cap_data : m_wdata_o);
                wr_strb_q.push_back(got_w ? cap_strb : m_wstrb_o);
                got_aw     <= 1'b0;
                got_w      <= 1'b0;
                m_bvalid_i <= 1'b1;
                m_bresp_i  <= bresp_cfg;
            end else begin
                if (m_awvalid_o && m_awready_i) begin
                    got_aw   <= 1'b1;
                    cap_addr <= m_awaddr_o;
                end
                if (m_wvalid_o && m_wready_i) begin
                    got_w    <= 1'b1;
                    cap_data <= m_wdata_o;
                    cap_strb <= m_wstrb_o;
                end
            end
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_strb_q.delete();
    endtask

    task automatic do_reset();
        rstn_i       = 1'b0;
        char_valid_i = 1'b0;
        char_data_i  = 8'h00;
        m_awready_i  = 1'b1;
        m_wready_i   = 1'b1;
        bresp_cfg    = 2'b00;
        repeat (3) @(negedge clk_i);
        clear_log();
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    // Called at a negedge; returns the number of extra negedges waited
    task automatic wait_ready(output int cyc);
        int n;
        n = 0;
        while (!char_ready_o && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        cyc = n;
        if (!char_ready_o) begin
            checks++;
            failures++;
            $display("FAIL timeout_ready: char_ready_o=%b after %0d cycles, need 1", char_ready_o, n);
        end
    endtask

    // Leaves the caller at the first negedge after the byte handshake
    task automatic send_char(input logic [7:0] c);
        int n;
        @(negedge clk_i);
        wait_ready(n);
        char_valid_i = 1'b1;
        char_data_i  = c;
        @(negedge clk_i);
        char_valid_i = 1'b0;
    endtask

    task automatic send_and_wait(input logic [7:0] c);
        int n;
        send_char(c);
        wait_ready(n);
    endtask

    task automatic test_reset();
        rstn_i       = 1'b0;
        char_valid_i = 1'b0;
        char_data_i  = 8'h00;
        m_awready_i  = 1'b1;
        m_wready_i   = 1'b1;
        bresp_cfg    = 2'b00;
        #3;
        checks++;
        if ({m_awvalid_o, m_wvalid_o, m_bready_o, char_ready_o, busy_o, err_o} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_flags: got %b need 000000", {m_awvalid_o, m_wvalid_o, m_bready_o, char_ready_o, busy_o, err_o});
        end
        checks++;
        if ({cursor_col_o, cursor_row_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_cursor: got col %0d row %0d need 0,0", cursor_col_o, cursor_row_o);
        end
        checks++;
        if ({m_awaddr_o, m_wdata_o, m_wstrb_o} !== 51'h0) begin
            failures++;
            $display("FAIL reset_payload: got %h %h %h need zeros", m_awaddr_o, m_wdata_o, m_wstrb_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (char_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready %b busy %b need 1 0", char_ready_o, busy_o);
        end
    endtask

    task automatic test_single_char();
        int n;
        do_reset();
        send_char(8'h41);
        checks++;
        if ({m_awvalid_o, m_wvalid_o, char_ready_o, busy_o} !== 4'b1101) begin
            failures++;
            $display("FAIL a_latency: aw/w/ready/busy %b need 1101", {m_awvalid_o, m_wvalid_o, char_ready_o, busy_o});
        end
        wait_ready(n);
        // IDLE, WRITE, WAIT_B, IDLE: ready again two negedges after the first WRITE cycle
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL a_throughput: ready after %0d cycles need 2", n);
        end
        checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 15'h4000 || wr_data_q[0] !== 32'h41414141 || wr_strb_q[0] !== 4'b0001) begin
            failures++;
            $display("FAIL a_write: n=%0d addr %h data %h strb %b need 1 4000 41414141 0001",
                     wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], wr_strb_q[0]);
        end
        checks++;
        if (cursor_col_o !== 7'd1 || cursor_row_o !== 5'd0) begin
            failures++;
            $display("FAIL a_cursor: got %0d,%0d need 1,0", cursor_col_o, cursor_row_o);
        end
    endtask

    task automatic test_row_wrap();
        do_reset();
        for (int i = 0; i < 82; i++) send_and_wait(8'h78);
        checks++;
        if (wr_addr_q.size() !== 82) begin
            failures++;
            $display("FAIL wrap_count: got %0d need 82", wr_addr_q.size());
        end
        checks++;
        if (wr_addr_q[79] !== 15'h404F || wr_strb_q[79] !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_80th: addr %h strb %b need 404f 1000", wr_addr_q[79], wr_strb_q[79]);
        end
        checks++;
        if (wr_addr_q[80] !== 15'h4050 || wr_strb_q[80] !== 4'b0001 || wr_data_q[80] !== 32'h78787878) begin
            failures++;
            $display("FAIL wrap_81st: addr %h strb %b data %h need 4050 0001 78787878", wr_addr_q[80], wr_strb_q[80], wr_data_q[80]);
        end
        checks++;
        if (cursor_col_o !== 7'd2 || cursor_row_o !== 5'd1) begin
            failures++;
            $display("FAIL wrap_cursor: got %0d,%0d need 2,1", cursor_col_o, cursor_row_o);
        end
    endtask

    task automatic test_last_cell();
        do_reset();
        send_and_wait(8'h71);
        send_and_wait(8'h0D);
        checks++;
        if (cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0 || wr_addr_q.size() !== 1) begin
            failures++;
            $display("FAIL cr: cursor %0d,%0d writes %0d need 0,0 1", cursor_col_o, cursor_row_o, wr_addr_q.size());
        end
        for (int i = 0; i < 30; i++) send_and_wait(8'h0A);
        checks++;
        if (cursor_row_o !== 5'd0 || wr_addr_q.size() !== 1) begin
            failures++;
            $display("FAIL lf_wrap: row %0d writes %0d need 0 1", cursor_row_o, wr_addr_q.size());
        end
        for (int i = 0; i < 29; i++) send_and_wait(8'h0A);
        for (int i = 0; i < 79; i++) send_and_wait(8'h79);
        checks++;
        if (cursor_col_o !== 7'd79 || cursor_row_o !== 5'd29) begin
            failures++;
            $display("FAIL last_pos: got %0d,%0d need 79,29", cursor_col_o, cursor_row_o);
        end
        clear_log();
        send_and_wait(8'h7A);
        checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 15'h495F || wr_strb_q[0] !== 4'b1000 || wr_data_q[0] !== 32'h7A7A7A7A) begin
            failures++;
            $display("FAIL last_write: n=%0d addr %h strb %b data %h need 1 495f 1000 7a7a7a7a",
                     wr_addr_q.size(), wr_addr_q[0], wr_strb_q[0], wr_data_q[0]);
        end
        checks++;
        if (cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0) begin
            failures++;
            $display("FAIL last_cursor: got %0d,%0d need 0,0", cursor_col_o, cursor_row_o);
        end
    endtask

    task automatic test_backspace();
        do_reset();
        send_and_wait(8'h61);
        send_and_wait(8'h62);
        send_and_wait(8'h08);
        checks++;
        if (wr_addr_q.size() !== 3 || wr_addr_q[2] !== 15'h4001 || wr_data_q[2] !== 32'h20202020 || wr_strb_q[2] !== 4'b0010) begin
            failures++;
            $display("FAIL bs_write: n=%0d addr %h data %h strb %b need 3 4001 20202020 0010",
                     wr_addr_q.size(), wr_addr_q[2], wr_data_q[2], wr_strb_q[2]);
        end
        checks++;
        if (cursor_col_o !== 7'd1 || cursor_row_o !== 5'd0) begin
            failures++;
            $display("FAIL bs_cursor: got %0d,%0d need 1,0", cursor_col_o, cursor_row_o);
        end
        send_and_wait(8'h08);
        send_and_wait(8'h08);
        send_and_wait(8'h01);
        checks++;
        if (wr_addr_q.size() !== 4 || wr_addr_q[3] !== 15'h4000 || wr_strb_q[3] !== 4'b0001 || cursor_col_o !== 7'd0) begin
            failures++;
            $display("FAIL bs_col0: n=%0d addr %h strb %b col %0d need 4 4000 0001 0",
                     wr_addr_q.size(), wr_addr_q[3], wr_strb_q[3], cursor_col_o);
        end
    endtask

    task automatic test_clear();
        int n, busy_low, bad;
        do_reset();
        send_and_wait(8'h61);
        send_and_wait(8'h62);
        clear_log();
        send_char(8'h0C);
        n = 0;
        busy_low = 0;
        while (wr_addr_q.size() < 600 && n < BOUND) begin
            if (busy_o !== 1'b1) busy_low++;
            @(negedge clk_i);
            n++;
        end
        wait_ready(n);
        checks++;
        if (busy_low !== 0) begin
            failures++;
            $display("FAIL ff_busy: busy low on %0d cycles need 0", busy_low);
        end
        checks++;
        if (wr_addr_q.size() !== 600) begin
            failures++;
            $display("FAIL ff_count: got %0d writes need 600", wr_addr_q.size());
        end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 15'h4000 + 15'(4 * i) || wr_data_q[i] !== 32'h20202020 || wr_strb_q[i] !== 4'hF) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL ff_beats: %0d bad beats need 0 (last addr %h)", bad, wr_addr_q[wr_addr_q.size()-1]);
        end
        checks++;
        if (cursor_col_o !== 7'd0 || cursor_row_o !== 5'd0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ff_end: cursor %0d,%0d busy %b need 0,0 0", cursor_col_o, cursor_row_o, busy_o);
        end
    endtask

    task automatic test_stall_error();
        int n, unstable;
        do_reset();
        m_wready_i = 1'b0;
        bresp_cfg  = 2'b10;
        send_char(8'h6B);
        @(negedge clk_i);
        checks++;
        if (m_awvalid_o !== 1'b0 || m_wvalid_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_split: aw %b w %b need 0 1", m_awvalid_o, m_wvalid_o);
        end
        unstable = 0;
        repeat (3) begin
            if (m_wvalid_o !== 1'b1 || m_wdata_o !== 32'h6B6B6B6B || m_wstrb_o !== 4'b0001) unstable++;
            @(negedge clk_i);
        end
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable cycles need 0", unstable);
        end
        m_wready_i = 1'b1;
        wait_ready(n);
        checks++;
        if (err_o !== 1'b1 || wr_addr_q.size() !== 1 || wr_data_q[0] !== 32'h6B6B6B6B) begin
            failures++;
            $display("FAIL err_set: err %b n=%0d data %h need 1 1 6b6b6b6b", err_o, wr_addr_q.size(), wr_data_q[0]);
        end
        bresp_cfg = 2'b00;
        send_and_wait(8'h6D);
        checks++;
        if (err_o !== 1'b1 || cursor_col_o !== 7'd2) begin
            failures++;
            $display("FAIL err_sticky: err %b col %0d need 1 2", err_o, cursor_col_o);
        end
        m_awready_i = 1'b0;
        m_wready_i  = 1'b0;
        send_char(8'h6E);
        checks++;
        if (m_awvalid_o !== 1'b1 || m_awaddr_o !== 15'h4002) begin
            failures++;
            $display("FAIL midrst_pre: awvalid %b addr %h need 1 4002", m_awvalid_o, m_awaddr_o);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({m_awvalid_o, m_wvalid_o, m_bready_o, busy_o, err_o, char_ready_o} !== 6'b000000 || cursor_col_o !== 7'd0) begin
            failures++;
            $display("FAIL midrst: aw/w/b/busy/err/ready %b col %0d need 000000 0",
                     {m_awvalid_o, m_wvalid_o, m_bready_o, busy_o, err_o, char_ready_o}, cursor_col_o);
        end
        @(negedge clk_i);
        m_awready_i = 1'b1;
        m_wready_i  = 1'b1;
        rstn_i      = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_row_wrap();
        test_last_cell();
        test_backspace();
        test_clear();
        test_stall_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
